// File: rtl/bp_be_acc_wide_reorder_if.sv
// Request, fill and release bundle for the wide-operand reorder buffer.
// The reorder buffer sits on the slave side; its producer and consumer sit on the master side.
interface bp_be_acc_wide_reorder_if #(
    parameter int data_width_p = 512,
    parameter int tag_width_p  = 2,
    parameter int els_p        = 8
);
    localparam int cnt_w = $clog2(els_p + 1);

    logic                    flush_i;
    logic                    req_v_i;
    logic                    req_hit_i;
    logic [tag_width_p-1:0]  req_tag_i;
    logic [data_width_p-1:0] req_data_i;
    logic                    ready_o;
    logic                    fill_v_i;
    logic [data_width_p-1:0] fill_data_i;
    logic                    v_o;
    logic [tag_width_p-1:0]  tag_o;
    logic [data_width_p-1:0] data_o;
    logic                    yumi_i;
    logic                    busy_o;
    logic [cnt_w-1:0]        count_o;
    logic                    spurious_o;

    modport slave (
        input  flush_i, req_v_i, req_hit_i, req_tag_i, req_data_i,
        input  fill_v_i, fill_data_i, yumi_i,
        output ready_o, v_o, tag_o, data_o, busy_o, count_o, spurious_o
    );

    modport master (
        output flush_i, req_v_i, req_hit_i, req_tag_i, req_data_i,
        output fill_v_i, fill_data_i, yumi_i,
        input  ready_o, v_o, tag_o, data_o, busy_o, count_o, spurious_o
    );
endinterface

// File: rtl/bp_be_acc_wide_reorder.sv
// In-order reorder buffer for wide operands: hits carry data, misses are filled later in order,
// and entries are released strictly in acceptance order. Flushed misses are absorbed by a drain counter.
module bp_be_acc_wide_reorder #(
    parameter int data_width_p  = 512,
    parameter int tag_width_p   = 2,
    parameter int els_p         = 8,
    parameter int drain_width_p = 6
) (
    input  logic clk_i,
    input  logic reset_i,
    bp_be_acc_wide_reorder_if.slave io
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    typedef logic [ptr_w-1:0]         ptr_t;
    typedef logic [cnt_w-1:0]         cnt_t;
    typedef logic [drain_width_p-1:0] drain_t;
    typedef logic [drain_width_p:0]   drain_sum_t;

    ptr_t   head_q, head_d;
    ptr_t   tail_q, tail_d;
    ptr_t   miss_q, miss_d;
    cnt_t   count_q, count_d;
    cnt_t   miss_cnt_q, miss_cnt_d;
    drain_t drain_q, drain_d;
    logic   spurious_q, spurious_d;
    logic [els_p-1:0] filled_q, filled_d;

    logic [tag_width_p-1:0]  tag_q  [els_p];
    logic [data_width_p-1:0] data_q [els_p];

    logic       head_v;
    logic       ready;
    logic       accept;
    logic       dequeue;
    logic       fill_drain;
    logic       fill_write;
    logic       fill_idle;
    drain_sum_t drain_sum;
    ptr_t       next_miss;
    logic       next_found;
    ptr_t       scan_idx;

    // Oldest unfilled entry after miss_q; only used while another unfilled entry remains.
    always_comb begin
        next_miss  = miss_q;
        next_found = 1'b0;
        scan_idx   = miss_q;
        for (int i = 1; i < els_p; i++) begin
            scan_idx = miss_q + ptr_t'(i);
            if (!next_found && !filled_q[scan_idx]) begin
                next_miss  = scan_idx;
                next_found = 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        head_v     = (count_q != '0) && filled_q[head_q];
        ready      = (count_q != cnt_t'(els_p));
        accept     = !io.flush_i && io.req_v_i && ready;
        dequeue    = !io.flush_i && io.yumi_i && head_v;
        fill_drain = !io.flush_i && io.fill_v_i && (drain_q != '0);
        fill_write = !io.flush_i && io.fill_v_i && (drain_q == '0) && (miss_cnt_q != '0);
        fill_idle  = io.fill_v_i && (drain_q == '0) && (miss_cnt_q == '0);
        drain_sum  = drain_sum_t'(drain_q) + drain_sum_t'(miss_cnt_q);

        head_d     = head_q;
        tail_d     = tail_q;
        miss_d     = miss_q;
        count_d    = count_q;
        miss_cnt_d = miss_cnt_q;
        drain_d    = drain_q;
        filled_d   = filled_q;
        spurious_d = 1'b0;

        if (io.flush_i) begin
            head_d     = '0;
            tail_d     = '0;
            miss_d     = '0;
            count_d    = '0;
            miss_cnt_d = '0;
            drain_d    = drain_sum[drain_width_p-1:0];
            // A fill racing the flush is charged against the drain it creates.
            if (io.fill_v_i) begin
                if (drain_sum != '0) drain_d = drain_d - drain_t'(1);
                else                 spurious_d = 1'b1;
            end
        end else begin
            if (accept)  tail_d = tail_q + ptr_t'(1);
            if (dequeue) head_d = head_q + ptr_t'(1);
            count_d    = count_q + cnt_t'(accept) - cnt_t'(dequeue);
            miss_cnt_d = miss_cnt_q + cnt_t'(accept && !io.req_hit_i) - cnt_t'(fill_write);
            if (fill_drain) drain_d = drain_q - drain_t'(1);
            spurious_d = fill_idle;

            if (fill_write) filled_d[miss_q] = 1'b1;
            if (accept)     filled_d[tail_q] = io.req_hit_i;

            // With no older miss left, the pointer lands on the first unfilled newcomer or the tail.
            if ((miss_cnt_q - cnt_t'(fill_write)) != '0)
                miss_d = fill_write ? next_miss : miss_q;
            else
                miss_d = (accept && !io.req_hit_i) ? tail_q : tail_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            miss_q     <= '0;
            count_q    <= '0;
            miss_cnt_q <= '0;
            drain_q    <= '0;
            spurious_q <= 1'b0;
            filled_q   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            miss_q     <= miss_d;
            count_q    <= count_d;
            miss_cnt_q <= miss_cnt_d;
            drain_q    <= drain_d;
            spurious_q <= spurious_d;
            filled_q   <= filled_d;
        end
    end

    // NOTE: payload storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tag_q[tail_q] <= io.req_tag_i;
            if (io.req_hit_i) data_q[tail_q] <= io.req_data_i;
        end
        if (fill_write) data_q[miss_q] <= io.fill_data_i;
    end

    assign io.ready_o    = ready;
    assign io.v_o        = head_v;
    assign io.tag_o      = tag_q[head_q];
    assign io.data_o     = data_q[head_q];
    assign io.busy_o     = (count_q != '0) || (drain_q != '0);
    assign io.count_o    = count_q;
    assign io.spurious_o = spurious_q;

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) io.yumi_i |-> head_v)
        else $error("yumi_i asserted while v_o is low");

    a_drain_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        io.flush_i |-> !drain_sum[drain_width_p])
        else $error("drain counter overflow on flush");
endmodule

// File: doc/bp_be_acc_wide_reorder.md
Name: bp_be_acc_wide_reorder

Overview:
- Parametrised in-order reorder buffer for wide (cache-block) operands feeding the accelerator pipe's datapath unit.
- Requests arrive in program order, each either a hit (data supplied with the request) or a miss (data supplied later by an in-order fill stream).
- The block releases entries strictly in request order, whatever the hit/miss interleaving. It replaces the fixed three-queue structure with one circular buffer of configurable depth.
- It adds flush with in-flight-fill absorption, backpressure instead of overflow, and spurious-fill detection.

Parameters:
data_width_p, 512, width of one wide operand
tag_width_p, 2, per-request sideband carried with data (e.g. {act_not_wt, last})
els_p, 8, buffer entries; power of two, >=2
drain_width_p, 6, width of flushed-miss drain counter; must be >= $clog2(els_p+1)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
flush_i  in  1  discard all buffered entries
req_v_i  in  1  request valid
req_hit_i  in  1  1=data present on req_data_i, 0=miss
req_tag_i  in  tag_width_p  request sideband
req_data_i  in  data_width_p  hit data, ignored on miss
ready_o  out  1  request accept (valid-ready)
fill_v_i  in  1  late miss data valid, always accepted
fill_data_i  in  data_width_p  late miss data
v_o  out  1  head entry complete
tag_o  out  tag_width_p  head tag
data_o  out  data_width_p  head data
yumi_i  in  1  consume head; legal only when v_o=1
busy_o  out  1  any entry allocated
count_o  out  $clog2(els_p+1)  allocated entries
spurious_o  out  1  one-cycle pulse: fill arrived with no outstanding or draining miss

Behaviour:
- Reset (async, active-high): all pointers, count and drain counter reset to 0. Outputs: v_o=0, ready_o=1, busy_o=0, count_o=0, spurious_o=0. Data storage is not reset.
- State: head_ptr, tail_ptr, miss_ptr (oldest unfilled entry), count, drain_cnt. Per entry: tag, data, filled bit.
- Accept: req_v_i & ready_o. ready_o = (count != els_p). There is no same-cycle bypass of a dequeue into a full buffer.
- On accept, the entry is written at tail_ptr and tail_ptr increments modulo els_p. filled = req_hit_i.
- Fill: applies only to misses allocated in earlier cycles.
  - If drain_cnt != 0: decrement drain_cnt and discard the data.
  - Else, if an unfilled entry exists: write data, set filled, advance miss_ptr to the next unfilled entry (or tail).
  - Else: discard and pulse spurious_o in the next cycle.
- Same-cycle miss request and fill: the fill never targets the newly allocated entry.
- Output: v_o = (count != 0) & filled[head]. tag_o/data_o come from the head entry.
- Latency: data written in cycle t is visible at the output in cycle t+1; nothing is combinationally forwarded.
- yumi_i frees the head in the same cycle; head_ptr increments modulo els_p.
- Simultaneous accept and yumi: count is unchanged.
- yumi_i with v_o=0 is illegal; an assertion fires, with no state change.
- Order: entries leave in strict acceptance order. A filled hit behind an unfilled miss waits.
- Flush (synchronous, takes priority over same-cycle req, fill and yumi, which are all ignored):
  - Pointers and count clear next cycle.
  - drain_cnt += number of unfilled entries at flush. A fill on the same cycle as flush is counted as consumed by the drain.
  - ready_o stays 1 during draining.
  - Subsequent new misses are filled only after drain_cnt reaches 0.
- drain_cnt saturation (overflow) is illegal and asserted.
- busy_o = (count != 0) | (drain_cnt != 0).
- Wrap-around: all pointers are els_p-modulo. Full and empty are distinguished by count, not by pointer equality.

Test Plan:
- Reset mid-stream with 3 entries buffered -> same cycle: v_o=0, count_o=0, ready_o=1; the next request lands in entry 0.
- Hit tag 2'b01 data A, cycle 0 -> v_o=1 at cycle 1 with tag 01, data A; yumi -> count_o=0 at cycle 2.
- Sequence miss M1(tag 00), hit H(tag 11, data B), miss M2(tag 10); then fills F1, F2 -> output order F1/00, B/11, F2/10. v_o stays 0 until F1 is written.
- els_p=8: 8 misses accepted, no yumi -> ready_o=0. Ninth request held stable and accepted the cycle after the first fill and yumi. Pointers wrap cleanly over 3 full laps.
- Flush with 2 unfilled misses + 1 filled hit -> count_o=0 next cycle, drain_cnt=2. New miss N, then fills X, Y, Z -> X and Y discarded, Z delivered for N, spurious_o never asserts.
- Fill with empty buffer and drain_cnt=0 -> spurious_o=1 for exactly one cycle; state unchanged.
